nr2u_rdrsp_buf: RTL and testbench

//  Per-read-port request/response front end for the nr2u 1r1w memory: accepts client reads on a valid/ready

---
 rtl/nr2u_rdrsp_buf.sv | 155 +++++++++++++++
 tb/tb_nr2u_rdrsp_buf.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nr2u_rdrsp_buf.sv
// nr2u_rdrsp_buf: per-read-port request issue, fixed-latency return check and
// credit-protected first-word-fall-through response buffer for the nr2u 1r1w memory.

module nr2u_rdrsp_buf_chk (
   input logic clk,
   input logic rst,
   input logic push,
   input logic full
);
   // Credits reserve a slot for every in-flight read, so a full FIFO never sees a push.
   no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

module nr2u_rdrsp_buf #(
   parameter int WIDTH      = 32,
   parameter int BITADDR    = 13,
   parameter int BITPADR    = 14,
   parameter int DEPTH      = 8,
   parameter int BITDPTH    = 3,
   parameter int READ_DELAY = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ready,
   input  logic               rq_vld,
   input  logic [BITADDR-1:0] rq_addr,
   output logic               rq_rdy,
   output logic               ru_read,
   output logic [BITADDR-1:0] ru_addr,
   input  logic               ru_vld,
   input  logic [WIDTH-1:0]   ru_dout,
   input  logic               ru_serr,
   input  logic               ru_derr,
   input  logic [BITPADR-1:0] ru_padr,
   output logic               rs_vld,
   output logic [WIDTH-1:0]   rs_dout,
   output logic               rs_serr,
   output logic               rs_derr,
   output logic [BITPADR-1:0] rs_padr,
   input  logic               rs_rdy,
   output logic               err_proto,
   output logic [BITDPTH:0]   occ
);
   localparam int ENTW = WIDTH + 2 + BITPADR;
   localparam int SUPW = $clog2(READ_DELAY + 1);
   localparam logic [BITDPTH:0] DEPTH_V = (BITDPTH + 1)'(DEPTH);
   localparam logic [SUPW-1:0]  SUP_END = SUPW'(READ_DELAY);

   logic [ENTW-1:0]       mem_r [DEPTH];
   logic [BITDPTH:0]      wr_ptr_r;
   logic [BITDPTH:0]      rd_ptr_r;
   logic [BITDPTH:0]      occ_r;
   logic [READ_DELAY-1:0] pipe_r;
   logic [SUPW-1:0]       sup_cnt_r;
   logic                  ru_read_r;
   logic [BITADDR-1:0]    ru_addr_r;
   logic                  err_r;

   logic                  accept_s;
   logic                  expected_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  miss_s;
   logic                  stray_s;
   logic                  empty_s;
   logic                  full_s;
   logic [ENTW-1:0]       head_s;

   assign empty_s    = (wr_ptr_r == rd_ptr_r);
   assign full_s     = (wr_ptr_r[BITDPTH] != rd_ptr_r[BITDPTH]) &&
                       (wr_ptr_r[BITDPTH-1:0] == rd_ptr_r[BITDPTH-1:0]);
   assign expected_s = pipe_r[READ_DELAY-1];
   assign rq_rdy     = ready & (occ_r < DEPTH_V);
   assign accept_s   = rq_vld & rq_rdy;
   assign push_s     = ru_vld & expected_s;
   assign pop_s      = rs_rdy & ~empty_s;
   assign miss_s     = expected_s & ~ru_vld;
   // Stray returns right after reset release may belong to reads issued before reset.
   assign stray_s    = ru_vld & ~expected_s & (sup_cnt_r == SUP_END);

   assign head_s  = empty_s ? {ENTW{1'b0}} : mem_r[rd_ptr_r[BITDPTH-1:0]];
   assign {rs_dout, rs_serr, rs_derr, rs_padr} = head_s;
   assign rs_vld    = ~empty_s;
   assign ru_read   = ru_read_r;
   assign ru_addr   = ru_addr_r;
   assign err_proto = err_r;
   assign occ       = occ_r;

   // Issue register and the expected-return shift pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ru_read_r <= 1'b0;
         ru_addr_r <= {BITADDR{1'b0}};
         pipe_r    <= {READ_DELAY{1'b0}};
      end else begin
         ru_read_r <= accept_s;
         if (accept_s) begin
            ru_addr_r <= rq_addr;
         end else begin
            ru_addr_r <= ru_addr_r;
         end
         pipe_r[0] <= ru_read_r;
         for (int i = 1; i < READ_DELAY; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   // Response storage; contents are don't-care until a pointer covers them.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[BITDPTH-1:0]] <= {ru_dout, ru_serr, ru_derr, ru_padr};
      end
   end

   // FIFO pointers and occupancy (buffered entries plus reads in flight).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(BITDPTH + 1){1'b0}};
         rd_ptr_r <= {(BITDPTH + 1){1'b0}};
         occ_r    <= {(BITDPTH + 1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{BITDPTH{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{BITDPTH{1'b0}}, 1'b1};
         end
         occ_r <= occ_r + (BITDPTH + 1)'(accept_s) - (BITDPTH + 1)'(pop_s)
                        - (BITDPTH + 1)'(miss_s);
      end
   end

   // Sticky protocol error and post-reset stray-return suppression window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r     <= 1'b0;
         sup_cnt_r <= {SUPW{1'b0}};
      end else begin
         if (miss_s || stray_s) begin
            err_r <= 1'b1;
         end
         if (sup_cnt_r != SUP_END) begin
            sup_cnt_r <= sup_cnt_r + {{(SUPW - 1){1'b0}}, 1'b1};
         end
      end
   end

   nr2u_rdrsp_buf_chk u_chk (
      .clk  (clk),
      .rst  (rst),
      .push (push_s),
      .full (full_s)
   );
endmodule

// File: tb/tb_nr2u_rdrsp_buf.sv
// Directed bench for nr2u_rdrsp_buf: a fixed-latency memory model answers issued reads,
// and a scoreboard of expected responses is checked at every FIFO pop.

module tb_nr2u_rdrsp_buf;
   localparam int WIDTH = 32, BITADDR = 13, BITPADR = 14, DEPTH = 8, BITDPTH = 3, RD = 4;

   typedef struct {
      int                 due;
      logic [BITADDR-1:0] addr;
   } pend_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               ready = 1'b0;
   logic               rq_vld = 1'b0;
   logic [BITADDR-1:0] rq_addr = '0;
   logic               rq_rdy;
   logic               ru_read;
   logic [BITADDR-1:0] ru_addr;
   logic               ru_vld = 1'b0;
   logic [WIDTH-1:0]   ru_dout = '0;
   logic               ru_serr = 1'b0;
   logic               ru_derr = 1'b0;
   logic [BITPADR-1:0] ru_padr = '0;
   logic               rs_vld;
   logic [WIDTH-1:0]   rs_dout;
   logic               rs_serr;
   logic               rs_derr;
   logic [BITPADR-1:0] rs_padr;
   logic               rs_rdy = 1'b0;
   logic               err_proto;
   logic [BITDPTH:0]   occ;

   int                 n_chk = 0;
   int                 n_pass = 0;
   int                 cyc_n = 0;
   logic               withhold = 1'b0;
   logic               inject = 1'b0;
   logic [BITADDR-1:0] req_q[$];
   pend_t              pend_q[$];
   logic [63:0]        sb_q[$];

   nr2u_rdrsp_buf #(
      .WIDTH(WIDTH), .BITADDR(BITADDR), .BITPADR(BITPADR),
      .DEPTH(DEPTH), .BITDPTH(BITDPTH), .READ_DELAY(RD)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .rq_vld(rq_vld), .rq_addr(rq_addr), .rq_rdy(rq_rdy),
      .ru_read(ru_read), .ru_addr(ru_addr),
      .ru_vld(ru_vld), .ru_dout(ru_dout), .ru_serr(ru_serr), .ru_derr(ru_derr), .ru_padr(ru_padr),
      .rs_vld(rs_vld), .rs_dout(rs_dout), .rs_serr(rs_serr), .rs_derr(rs_derr), .rs_padr(rs_padr),
      .rs_rdy(rs_rdy), .err_proto(err_proto), .occ(occ)
   );

   always #5 clk = ~clk;

   // Memory contents: {pad, dout, serr, derr, padr} as a function of the address.
   function automatic logic [63:0] resp_of(input logic [BITADDR-1:0] a);
      return {16'h0000, 32'hA5A5_A5A0 ^ {19'h00000, a}, a[0], a[1], 1'b1, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic issue(input logic [BITADDR-1:0] a);
      bit ok;
      ok = 1'b0;
      rq_vld = 1'b1;
      rq_addr = a;
      for (int k = 0; k < 50 && !ok; k++) begin
         smp();
         if (rq_rdy) begin
            req_q.push_back(a);
            ok = 1'b1;
         end
         tick();
      end
      rq_vld = 1'b0;
      chk("issue_accept", 64'(ok), 64'd1);
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      rs_rdy = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         smp();
         if (occ == '0 && !rs_vld) done = 1'b1;
         else tick();
      end
      chk("drain_done", 64'(done), 64'd1);
      chk("drain_sb_left", 64'(sb_q.size()), 64'd0);
      tick();
      rs_rdy = 1'b0;
   endtask

   // Memory model, request-order check and pop-side scoreboard compare.
   initial begin : model
      pend_t       p;
      logic [63:0] e;
      forever begin
         @(posedge clk);
         #2;
         cyc_n++;
         ru_vld = 1'b0;
         if (rst) begin
            pend_q.delete();
         end else if (pend_q.size() > 0 && pend_q[0].due == cyc_n) begin
            p = pend_q.pop_front();
            if (!withhold) begin
               e = resp_of(p.addr);
               ru_vld = 1'b1;
               ru_dout = e[47:16];
               ru_serr = e[15];
               ru_derr = e[14];
               ru_padr = e[13:0];
               sb_q.push_back(e);
            end
         end
         if (inject && !ru_vld) begin
            ru_vld = 1'b1;
            ru_dout = 32'hDEAD_BEEF;
            ru_serr = 1'b1;
            ru_derr = 1'b1;
            ru_padr = 14'h3FFF;
         end
         @(negedge clk);
         if (!rst && ru_read) begin
            if (req_q.size() == 0) begin
               chk("ru_read_unrequested", 64'(ru_read), 64'd0);
            end else begin
               chk("ru_addr", 64'(ru_addr), 64'(req_q[0]));
               p.due = cyc_n + RD;
               p.addr = req_q.pop_front();
               pend_q.push_back(p);
            end
         end
         if (!rst && rs_vld && rs_rdy) begin
            if (sb_q.size() == 0) chk("rs_unexpected", 64'(rs_vld), 64'd0);
            else chk("rs_entry", {16'h0000, rs_dout, rs_serr, rs_derr, rs_padr}, sb_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int acc;
      // Reset state
      repeat (3) tick();
      smp();
      chk("rst_rs_vld", 64'(rs_vld), 64'd0);
      chk("rst_occ", 64'(occ), 64'd0);
      chk("rst_err", 64'(err_proto), 64'd0);
      chk("rst_ru_read", 64'(ru_read), 64'd0);
      chk("rst_rq_rdy", 64'(rq_rdy), 64'd0);
      tick();
      rst = 1'b0;
      ready = 1'b1;
      repeat (RD + 2) tick();

      // 1: single read, latency and data
      issue(13'h005);
      smp();
      chk("t1_ru_read", 64'(ru_read), 64'd1);
      chk("t1_ru_addr", 64'(ru_addr), 64'h005);
      chk("t1_occ", 64'(occ), 64'd1);
      repeat (RD) tick();
      smp();
      chk("t1_rs_vld_early", 64'(rs_vld), 64'd0);
      tick();
      smp();
      chk("t1_rs_vld", 64'(rs_vld), 64'd1);
      chk("t1_rs_dout", 64'(rs_dout), 64'hA5A5_A5A5);
      tick();
      rs_rdy = 1'b1;
      smp();
      tick();
      rs_rdy = 1'b0;
      smp();
      chk("t1_empty", 64'(rs_vld), 64'd0);
      chk("t1_occ0", 64'(occ), 64'd0);
      tick();

      // 2: credit limit with a stalled consumer
      acc = 0;
      rq_vld = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rq_addr = 13'(16 + i);
         smp();
         if (rq_rdy) begin
            req_q.push_back(rq_addr);
            acc++;
         end
         tick();
      end
      rq_vld = 1'b0;
      chk("t2_accepted", 64'(acc), 64'd8);
      smp();
      chk("t2_occ_full", 64'(occ), 64'd8);
      chk("t2_rq_rdy_full", 64'(rq_rdy), 64'd0);
      repeat (RD + 2) tick();
      smp();
      chk("t2_occ_landed", 64'(occ), 64'd8);
      chk("t2_rs_vld", 64'(rs_vld), 64'd1);
      tick();
      rs_rdy = 1'b1;
      smp();
      tick();
      rs_rdy = 1'b0;
      smp();
      chk("t2_occ_after_pop", 64'(occ), 64'd7);
      chk("t2_rq_rdy_after_pop", 64'(rq_rdy), 64'd1);
      tick();
      drain();

      // 3: streaming with a toggling consumer, pointers wrap
      acc = 0;
      rq_vld = 1'b1;
      for (int k = 0; k < 400 && acc < 20; k++) begin
         rq_addr = 13'(200 + acc);
         rs_rdy = k[0];
         smp();
         if (rq_rdy) begin
            req_q.push_back(rq_addr);
            acc++;
         end
         tick();
      end
      rq_vld = 1'b0;
      chk("t3_accepted", 64'(acc), 64'd20);
      drain();
      chk("t3_err", 64'(err_proto), 64'd0);

      // 4a: unexpected return
      inject = 1'b1;
      tick();
      inject = 1'b0;
      smp();
      chk("t4_stray_err", 64'(err_proto), 64'd1);
      chk("t4_stray_fifo", 64'(rs_vld), 64'd0);
      chk("t4_stray_occ", 64'(occ), 64'd0);
      tick();
      rst = 1'b1;
      req_q.delete();
      pend_q.delete();
      sb_q.delete();
      tick();
      tick();
      rst = 1'b0;
      repeat (RD + 2) tick();
      smp();
      chk("t4_err_cleared", 64'(err_proto), 64'd0);
      tick();

      // 4b: missing return
      withhold = 1'b1;
      issue(13'h040);
      smp();
      chk("t4_miss_occ_pre", 64'(occ), 64'd1);
      repeat (RD) tick();
      smp();
      chk("t4_miss_occ_due", 64'(occ), 64'd1);
      chk("t4_miss_err_due", 64'(err_proto), 64'd0);
      tick();
      withhold = 1'b0;
      smp();
      chk("t4_miss_occ_post", 64'(occ), 64'd0);
      chk("t4_miss_err_post", 64'(err_proto), 64'd1);
      chk("t4_miss_fifo", 64'(rs_vld), 64'd0);
      tick();

      // 5: ready low blocks accepts, in-flight reads still land
      ready = 1'b0;
      rq_vld = 1'b1;
      rq_addr = 13'h111;
      smp();
      chk("t5_rdy_off_idle", 64'(rq_rdy), 64'd0);
      tick();
      ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 3; i++) begin
         rq_addr = 13'(i + 1);
         smp();
         if (rq_rdy) begin
            req_q.push_back(rq_addr);
            acc++;
         end
         tick();
      end
      ready = 1'b0;
      rq_addr = 13'h1FF;
      chk("t5_accepted", 64'(acc), 64'd3);
      smp();
      chk("t5_rdy_off_busy", 64'(rq_rdy), 64'd0);
      chk("t5_occ_inflight", 64'(occ), 64'd3);
      repeat (RD + 2) tick();
      smp();
      chk("t5_occ_landed", 64'(occ), 64'd3);
      chk("t5_rdy_still_off", 64'(rq_rdy), 64'd0);
      tick();
      rq_vld = 1'b0;
      drain();
      ready = 1'b1;

      // 6: reset mid-operation with 2 buffered and 3 in flight
      acc = 0;
      rq_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rq_addr = 13'(300 + i);
         smp();
         if (rq_rdy) begin
            req_q.push_back(rq_addr);
            acc++;
         end
         tick();
      end
      rq_vld = 1'b0;
      chk("t6_accepted", 64'(acc), 64'd5);
      repeat (RD - 2) tick();
      smp();
      chk("t6_occ_pre", 64'(occ), 64'd5);
      chk("t6_rs_vld_pre", 64'(rs_vld), 64'd1);
      rst = 1'b1;
      req_q.delete();
      pend_q.delete();
      sb_q.delete();
      inject = 1'b1;
      #1;
      chk("t6_rs_vld_rst", 64'(rs_vld), 64'd0);
      chk("t6_occ_rst", 64'(occ), 64'd0);
      chk("t6_err_rst", 64'(err_proto), 64'd0);
      chk("t6_ru_read_rst", 64'(ru_read), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      inject = 1'b0;
      smp();
      chk("t6_late_err", 64'(err_proto), 64'd0);
      chk("t6_late_fifo", 64'(rs_vld), 64'd0);
      chk("t6_late_occ", 64'(occ), 64'd0);
      tick();
      issue(13'h007);
      tick();
      drain();
      chk("t6_final_err", 64'(err_proto), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
